fp16_add_sequencer: RTL and testbench

//  Multi-cycle controller for the half-precision (1/5/10) add/subtract datapath.
//  It captures two operands, orders them by magnitude, and aligns the smaller

---
 rtl/fp16_add_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_fp16_add_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle half-precision add/subtract sequencer.
// Captures two operands on start, orders them by magnitude, aligns the smaller
// mantissa one bit per clock, adds or subtracts, renormalises one bit per clock
// and returns a packed result with a one-cycle done pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while idle
//   op_a, op_b, sub   operands {sign, exp, frac}; sub=1 computes op_a - op_b
//   busy              operation in flight (excludes the done cycle)
//   done              one-cycle pulse, result/overflow valid
//   result            packed result, held until the next done
//   overflow          result saturated to +/-inf
module fp16_add_sequencer #(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned FRAC_W    = 10,
    parameter int unsigned MAX_SHIFT = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    input  logic                    sub,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow
);

    localparam int unsigned W     = EXP_W + FRAC_W + 1;
    localparam int unsigned MAN_W = FRAC_W + 1;
    localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StArith, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               sign_l_q, sign_l_d, sign_s_q, sign_s_d;
    logic [EXP_W-1:0]   exp_q, exp_d, diff_q, diff_d;
    logic [MAN_W-1:0]   man_l_q, man_l_d, man_s_q, man_s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAN_W:0]     sum_q, sum_d;
    logic [W-1:0]       result_q, result_d;
    logic               overflow_q, overflow_d;

    // Operand decode for SETUP; exp==0 operands are treated as zero.
    logic               sa, sb, zero_a, zero_b, nan_a, nan_b, inf_a, inf_b, a_ge_b;
    logic [EXP_W-1:0]   ea, eb;
    logic [FRAC_W-1:0]  fa, fb;
    logic [W-2:0]       key_a, key_b;
    logic [MAN_W-1:0]   man_a, man_b;
    logic [MAN_W:0]     arith_sum;
    logic [EXP_W-1:0]   exp_inc, exp_dec;

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1];
    assign ea     = a_q[W-2 -: EXP_W];
    assign eb     = b_q[W-2 -: EXP_W];
    assign fa     = a_q[FRAC_W-1:0];
    assign fb     = b_q[FRAC_W-1:0];
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);
    assign nan_a  = (ea == EXP_MAX) && (fa != '0);
    assign nan_b  = (eb == EXP_MAX) && (fb != '0);
    assign inf_a  = (ea == EXP_MAX) && (fa == '0);
    assign inf_b  = (eb == EXP_MAX) && (fb == '0);
    assign key_a  = zero_a ? '0 : a_q[W-2:0];
    assign key_b  = zero_b ? '0 : b_q[W-2:0];
    assign a_ge_b = (key_a >= key_b);
    assign man_a  = zero_a ? '0 : {1'b1, fa};
    assign man_b  = zero_b ? '0 : {1'b1, fb};

    // |L| >= |S| after alignment, so the difference never wraps.
    assign arith_sum = (sign_l_q == sign_s_q) ? ({1'b0, man_l_q} + {1'b0, man_s_q})
                                              : ({1'b0, man_l_q} - {1'b0, man_s_q});
    assign exp_inc   = exp_q + EXP_W'(1);
    assign exp_dec   = exp_q - EXP_W'(1);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_l_d   = sign_l_q;
        sign_s_d   = sign_s_q;
        exp_d      = exp_q;
        diff_d     = diff_q;
        man_l_d    = man_l_q;
        man_s_d    = man_s_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d        = op_a;
                    b_d        = {op_b[W-1] ^ sub, op_b[W-2:0]};
                    overflow_d = 1'b0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                cnt_d = '0;
                if (nan_a || nan_b) begin
                    result_d = QNAN;
                    state_d  = StDone;
                end else if (inf_a && inf_b) begin
                    result_d = (sa == sb) ? a_q : QNAN;
                    state_d  = StDone;
                end else if (inf_a) begin
                    result_d = a_q;
                    state_d  = StDone;
                end else if (inf_b) begin
                    result_d = b_q;
                    state_d  = StDone;
                end else begin
                    if (a_ge_b) begin
                        sign_l_d = sa;
                        sign_s_d = sb;
                        exp_d    = ea;
                        man_l_d  = man_a;
                        man_s_d  = man_b;
                        diff_d   = ea - eb;
                    end else begin
                        sign_l_d = sb;
                        sign_s_d = sa;
                        exp_d    = eb;
                        man_l_d  = man_b;
                        man_s_d  = man_a;
                        diff_d   = eb - ea;
                    end
                    state_d = StShift;
                end
            end
            StShift: begin
                if (diff_q == '0) begin
                    state_d = StArith;
                end else begin
                    man_s_d = man_s_q >> 1;
                    diff_d  = diff_q - EXP_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    // The last permitted shift: anything still misaligned is dropped.
                    if (cnt_q == CNT_W'(MAX_SHIFT - 1)) begin
                        man_s_d = '0;
                        state_d = StArith;
                    end else if (diff_q == EXP_W'(1)) begin
                        state_d = StArith;
                    end
                end
            end
            StArith: begin
                if (arith_sum == '0) begin
                    result_d = '0;
                    state_d  = StDone;
                end else begin
                    sum_d   = arith_sum;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                // Each cycle performs one step and packs as soon as the step normalises.
                if (sum_q[MAN_W]) begin
                    if (exp_inc == EXP_MAX) begin
                        overflow_d = 1'b1;
                        result_d   = {sign_l_q, EXP_MAX, {FRAC_W{1'b0}}};
                    end else begin
                        result_d   = {sign_l_q, exp_inc, sum_q[FRAC_W:1]};
                    end
                    state_d = StDone;
                end else if (!sum_q[FRAC_W]) begin
                    if (exp_q == EXP_W'(1)) begin
                        result_d = {sign_l_q, {(W-1){1'b0}}};
                        state_d  = StDone;
                    end else begin
                        sum_d = sum_q << 1;
                        exp_d = exp_dec;
                        if (sum_q[FRAC_W-1]) begin
                            result_d = {sign_l_q, exp_dec, sum_q[FRAC_W-2:0], 1'b0};
                            state_d  = StDone;
                        end
                    end
                end else begin
                    result_d = {sign_l_q, exp_q, sum_q[FRAC_W-1:0]};
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            exp_q      <= '0;
            diff_q     <= '0;
            man_l_q    <= '0;
            man_s_q    <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_l_q   <= sign_l_d;
            sign_s_q   <= sign_s_d;
            exp_q      <= exp_d;
            diff_q     <= diff_d;
            man_l_q    <= man_l_d;
            man_s_q    <= man_s_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == StSetup) || (state_q == StShift) ||
                      (state_q == StArith) || (state_q == StNorm);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Self-checking bench for fp16_add_sequencer: directed vectors, randomized
// operations against an arithmetic reference model, reset and start-while-busy.
module tb_fp16_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        sub;
    logic        busy, done, overflow;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    fp16_add_sequencer #(
        .EXP_W    (5),
        .FRAC_W   (10),
        .MAX_SHIFT(12)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .sub     (sub),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level fp16 add with truncating alignment/normalisation,
    // flush-to-zero and a 12-step alignment cap; latency from the cycle budget.
    function automatic void model(input logic [15:0] a, input logic [15:0] b_raw,
                                  input logic s, output logic [15:0] r,
                                  output logic o, output int lat);
        logic [15:0] b;
        int ea, eb, fa, fb, ka, kb, el, es, ml, ms, sl, ss, diff, shifts, sum, n, e;
        bit flushed;
        b  = b_raw ^ {s, 15'b0};
        ea = int'(a[14:10]); fa = int'(a[9:0]);
        eb = int'(b[14:10]); fb = int'(b[9:0]);
        o  = 1'b0;
        lat = 2;
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) begin
            r = 16'h7E00; return;
        end
        if (ea == 31 && eb == 31) begin
            r = (a[15] == b[15]) ? a : 16'h7E00; return;
        end
        if (ea == 31) begin r = a; return; end
        if (eb == 31) begin r = b; return; end
        ka = (ea == 0) ? 0 : ea * 1024 + fa;
        kb = (eb == 0) ? 0 : eb * 1024 + fb;
        if (ka >= kb) begin
            el = ea; ml = (ea == 0) ? 0 : 1024 + fa; sl = int'(a[15]);
            es = eb; ms = (eb == 0) ? 0 : 1024 + fb; ss = int'(b[15]);
        end else begin
            el = eb; ml = (eb == 0) ? 0 : 1024 + fb; sl = int'(b[15]);
            es = ea; ms = (ea == 0) ? 0 : 1024 + fa; ss = int'(a[15]);
        end
        diff   = el - es;
        shifts = (diff == 0) ? 1 : ((diff < 12) ? diff : 12);
        ms     = (diff >= 12) ? 0 : (ms >> diff);
        sum    = (sl == ss) ? ml + ms : ml - ms;
        if (sum == 0) begin
            r = 16'h0000; lat = 3 + shifts; return;
        end
        e = el; n = 0; flushed = 0;
        if (sum >= 2048) begin
            sum = sum / 2; e = e + 1; n = 1;
            if (e >= 31) begin o = 1'b1; sum = 0; end
        end else begin
            while (sum < 1024) begin
                n++;
                if (e == 1) begin flushed = 1; break; end
                sum = sum * 2; e = e - 1;
            end
            if (n == 0) n = 1;
        end
        if (flushed) r = 16'(sl * 32768);
        else         r = 16'(sl * 32768 + e * 1024 + sum % 1024);
        lat = 3 + shifts + n;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input string tag, output logic [15:0] obs_r,
                          output logic obs_o, output int obs_lat);
        logic [15:0] er, prev;
        logic        eo;
        int          el, cyc;
        bit          stable, busy_ok;
        model(a, b, s, er, eo, el);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
        prev = result; stable = 1; busy_ok = 1; cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (result !== prev) stable = 0;
            @(negedge clk);
            cyc++;
        end
        obs_r = result; obs_o = overflow; obs_lat = cyc;
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        check({tag, " latency"}, 32'(cyc), 32'(el));
        check({tag, " busy at done"}, 32'(busy), 32'(0));
        check({tag, " busy during op"}, 32'(busy_ok), 32'(1));
        check({tag, " result held"}, 32'(stable), 32'(1));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'(0));
    endtask

    task automatic run_dir(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] xr, input logic xo, input int xlat,
                           input string tag);
        logic [15:0] r;
        logic        o;
        int          lat;
        run_op(a, b, s, tag, r, o, lat);
        check({tag, " vector result"}, 32'(r), 32'(xr));
        check({tag, " vector overflow"}, 32'(o), 32'(xo));
        check({tag, " vector latency"}, 32'(lat), 32'(xlat));
    endtask

    initial begin
        logic [15:0] a, b, r, er, got;
        logic        o, eo;
        int          lat, el, ndone;

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_dir(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 5,  "1+1");
        run_dir(16'h6400, 16'h3C00, 1'b0, 16'h6401, 1'b0, 14, "1024+1");
        run_dir(16'h3C00, 16'h6400, 1'b0, 16'h6401, 1'b0, 14, "1+1024");
        run_dir(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 4,  "1-1");
        run_dir(16'h3C00, 16'h3BFF, 1'b1, 16'h1400, 1'b0, 14, "1-0.99");
        run_dir(16'h7E00, 16'($urandom), 1'b0, 16'h7E00, 1'b0, 2, "nan");
        run_dir(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 2, "inf-inf");
        run_dir(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 1'b0, 16, "denorm");
        run_dir(16'h7800, 16'h3C00, 1'b0, 16'h7800, 1'b0, 16, "shift cap");
        run_dir(16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 5,  "underflow flush");
        run_dir(16'h3C00, 16'h3C01, 1'b0, 16'h4000, 1'b0, 5,  "round trunc");
        run_dir(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 5,  "overflow");

        // Reset while idle clears the held result and overflow immediately.
        #3 rst_n = 1'b0;
        #1;
        check("idle reset result", 32'(result), 32'(0));
        check("idle reset overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_dir(16'h6400, 16'h3C00, 1'b0, 16'h6401, 1'b0, 14, "pre reset op");
        @(negedge clk);
        op_a = 16'h7800; op_b = 16'h3C00; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy mid shift", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 32'(0));
        check("async reset done", 32'(done), 32'(0));
        check("async reset result", 32'(result), 32'(0));
        check("async reset overflow", 32'(overflow), 32'(0));
        repeat (20) @(negedge clk);
        check("no done in reset", 32'(done), 32'(0));
        rst_n = 1'b1;

        // A start pulse while busy must not launch a second operation.
        model(16'h6400, 16'h3C00, 1'b0, er, eo, el);
        @(negedge clk);
        op_a = 16'h6400; op_b = 16'h3C00; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op_a = 16'h3C00; op_b = 16'h3C00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin ndone++; got = result; end
            @(negedge clk);
        end
        check("busy start done count", 32'(ndone), 32'(1));
        check("busy start result", 32'(got), 32'(er));

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 2 == 0) b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
            run_op(a, b, 1'($urandom), "random", r, o, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
